// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator and the text/graphics path.
package vga_timing_pkg;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned COLOR_W = 12;
    localparam int unsigned CNT_W   = 10;

    // True when v lies in [lo, lo+len).
    function automatic logic in_span(input logic [CNT_W-1:0] v,
                                     input int unsigned lo,
                                     input int unsigned len);
        return (v >= CNT_W'(lo)) && (v < CNT_W'(lo + len));
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Single-bit delay line of DEPTH stages advancing on en; DEPTH=0 is a plain wire.
module sync_delay_line #(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, en};
            assign dout        = din;
        end else begin : g_shift
            logic [DEPTH-1:0] stage;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage <= {DEPTH{RESET_VAL}};
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan counters plus sync/blanking outputs delayed to line up with the colour pipeline.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               pix_tick,
    input  logic [COLOR_W-1:0] rgb_in,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] vga_rgb,
    output logic               frame_tick
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic x_wrap;
    logic y_wrap;
    logic hsync_raw;
    logic vsync_raw;
    logic hsync_dly;
    logic vsync_dly;
    logic video_dly;

    assign x_wrap = (pix_x == H_LAST);
    assign y_wrap = (pix_y == V_LAST);

    // Scan position; line counter steps only when the pixel counter wraps.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (pix_tick) begin
            pix_x <= x_wrap ? '0 : pix_x + CNT_W'(1);
            if (x_wrap) begin
                pix_y <= y_wrap ? '0 : pix_y + CNT_W'(1);
            end
        end
    end

    assign video_on   = (pix_x < CNT_W'(H_VIS)) && (pix_y < CNT_W'(V_VIS));
    assign hsync_raw  = !in_span(pix_x, H_VIS + H_FP, H_SYNC);
    assign vsync_raw  = !in_span(pix_y, V_VIS + V_FP, V_SYNC);
    assign frame_tick = pix_tick && x_wrap && y_wrap;

    sync_delay_line #(.DEPTH(PIPE_DLY), .RESET_VAL(1'b1)) u_hsync_dly (
        .clk  (CLK),
        .rst_n(RESET),
        .en   (pix_tick),
        .din  (hsync_raw),
        .dout (hsync_dly)
    );

    sync_delay_line #(.DEPTH(PIPE_DLY), .RESET_VAL(1'b1)) u_vsync_dly (
        .clk  (CLK),
        .rst_n(RESET),
        .en   (pix_tick),
        .din  (vsync_raw),
        .dout (vsync_dly)
    );

    sync_delay_line #(.DEPTH(PIPE_DLY), .RESET_VAL(1'b0)) u_video_dly (
        .clk  (CLK),
        .rst_n(RESET),
        .en   (pix_tick),
        .din  (video_on),
        .dout (video_dly)
    );

    // Output stage: blanking is applied with the delayed video flag so colour stays dark in sync.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            vga_rgb <= '0;
        end else if (pix_tick) begin
            hsync   <= hsync_dly;
            vsync   <= vsync_dly;
            vga_rgb <= video_dly ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: tick-count scan model checked every cycle on PIPE_DLY=2 and PIPE_DLY=0 builds.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    logic        clk;
    logic        rst_n;
    logic        pix_tick;
    logic [11:0] rgb_in;

    logic [9:0]  x2, y2, x0, y0;
    logic        von2, hs2, vs2, ft2;
    logic        von0, hs0, vs0, ft0;
    logic [11:0] rgb2, rgb0;

    int errors = 0;
    int checks = 0;

    logic toggle = 1'b0;
    logic ramp   = 1'b0;

    vga_sync_gen #(.PIPE_DLY(2)) dut (
        .CLK(clk), .RESET(rst_n), .pix_tick(pix_tick), .rgb_in(rgb_in),
        .pix_x(x2), .pix_y(y2), .video_on(von2), .hsync(hs2), .vsync(vs2),
        .vga_rgb(rgb2), .frame_tick(ft2)
    );

    vga_sync_gen #(.PIPE_DLY(0)) dut0 (
        .CLK(clk), .RESET(rst_n), .pix_tick(pix_tick), .rgb_in(rgb_in),
        .pix_x(x0), .pix_y(y0), .video_on(von0), .hsync(hs0), .vsync(vs0),
        .vga_rgb(rgb0), .frame_tick(ft0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
            if (errors >= 50) summary_and_finish();
        end
    endtask

    // Model: the scan position is simply the number of ticks since reset, folded by line/frame size.
    longint      t;
    logic [11:0] last_rgb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t        <= 0;
            last_rgb <= '0;
        end else if (pix_tick) begin
            t        <= t + 1;
            last_rgb <= rgb_in;
        end
    end

    function automatic int px(input longint k);
        return int'(k % 800);
    endfunction

    function automatic int py(input longint k);
        return int'((k / 800) % 525);
    endfunction

    function automatic int vis(input longint k);
        return (px(k) < 640 && py(k) < 480) ? 1 : 0;
    endfunction

    function automatic int exp_hs(input longint k, input int d);
        longint s = k - longint'(d) - 1;
        if (s < 0) return 1;
        return (px(s) >= 656 && px(s) < 752) ? 0 : 1;
    endfunction

    function automatic int exp_vs(input longint k, input int d);
        longint s = k - longint'(d) - 1;
        if (s < 0) return 1;
        return (py(s) >= 490 && py(s) < 492) ? 0 : 1;
    endfunction

    function automatic int exp_rgb(input longint k, input int d, input logic [11:0] c);
        longint s = k - longint'(d) - 1;
        if (s < 0) return 0;
        return (vis(s) == 1) ? int'(c) : 0;
    endfunction

    function automatic int exp_ft(input longint k, input logic tk);
        return (tk && px(k) == 799 && py(k) == 524) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("x2",   int'(x2),   px(t));
            chk("y2",   int'(y2),   py(t));
            chk("von2", int'(von2), vis(t));
            chk("hs2",  int'(hs2),  exp_hs(t, 2));
            chk("vs2",  int'(vs2),  exp_vs(t, 2));
            chk("rgb2", int'(rgb2), exp_rgb(t, 2, last_rgb));
            chk("ft2",  int'(ft2),  exp_ft(t, pix_tick));
            chk("x0",   int'(x0),   px(t));
            chk("y0",   int'(y0),   py(t));
            chk("von0", int'(von0), vis(t));
            chk("hs0",  int'(hs0),  exp_hs(t, 0));
            chk("vs0",  int'(vs0),  exp_vs(t, 0));
            chk("rgb0", int'(rgb0), exp_rgb(t, 0, last_rgb));
            chk("ft0",  int'(ft0),  exp_ft(t, pix_tick));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle) pix_tick = ~pix_tick;
        if (ramp)   rgb_in   = rgb_in + 12'h0B7;
        @(negedge clk);
    endtask

    task automatic wait_pos(input int wx, input int wy, input int budget);
        int n = 0;
        while (!(int'(x2) == wx && int'(y2) == wy) && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("reach_%0d_%0d", wx, wy),
            (int'(x2) == wx && int'(y2) == wy) ? 1 : 0, 1);
    endtask

    initial begin
        #30_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int ftn;
        int tog_seq [6];
        tog_seq = '{1, 1, 2, 2, 3, 3};

        rst_n    = 1'b1;
        pix_tick = 1'b1;
        rgb_in   = 12'hFFF;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_x",   int'(x2),   0);
        chk("rst_y",   int'(y2),   0);
        chk("rst_hs",  int'(hs2),  1);
        chk("rst_vs",  int'(vs2),  1);
        chk("rst_rgb", int'(rgb2), 0);
        chk("rst_ft",  int'(ft2),  0);
        chk("rst_hs0", int'(hs0),  1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("start_x", int'(x2), 1);

        // Right edge of the visible area: colour lags by 3 (D=2) and 1 (D=0).
        wait_pos(640, 0, 1000);
        chk("rgb_640",  int'(rgb2), 12'hFFF);
        chk("rgb0_640", int'(rgb0), 12'hFFF);
        step();
        chk("rgb0_641", int'(rgb0), 0);
        step();
        chk("rgb_642",  int'(rgb2), 12'hFFF);
        step();
        chk("rgb_643",  int'(rgb2), 0);

        // hsync edges and width.
        wait_pos(656, 0, 100);
        chk("hs0_656", int'(hs0), 1);
        step();
        chk("hs0_657", int'(hs0), 0);
        step();
        chk("hs_658",  int'(hs2), 1);
        step();
        chk("hs_659",  int'(hs2), 0);
        n = 0;
        while (hs2 == 1'b0 && n < 1000) begin
            n++;
            step();
        end
        chk("hs_width", n, 96);

        wait_pos(799, 100, 90000);
        chk("ft_line100", int'(ft2), 0);
        step();
        chk("wrap100_x", int'(x2), 0);
        chk("wrap100_y", int'(y2), 101);
        chk("wrap100_ft", int'(ft2), 0);

        // vsync edges and width.
        wait_pos(0, 490, 400000);
        chk("vs0_0_490", int'(vs0), 1);
        step();
        chk("vs0_1_490", int'(vs0), 0);
        step();
        chk("vs_2_490", int'(vs2), 1);
        step();
        chk("vs_3_490", int'(vs2), 0);
        n = 0;
        while (vs2 == 1'b0 && n < 2000) begin
            n++;
            step();
        end
        chk("vs_width", n, 1600);

        wait_pos(799, 524, 30000);
        chk("ft_frame",  int'(ft2), 1);
        chk("ft0_frame", int'(ft0), 1);
        step();
        chk("frame_x",  int'(x2), 0);
        chk("frame_y",  int'(y2), 0);
        chk("frame_ft", int'(ft2), 0);

        // Second frame with a changing colour, then reset in the middle of vsync.
        ramp = 1'b1;
        wait_pos(700, 491, 400000);
        chk("pre_rst_vs",  int'(vs2), 0);
        chk("pre_rst_hs",  int'(hs2), 0);
        chk("pre_rst_vs0", int'(vs0), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vs",  int'(vs2),  1);
        chk("arst_hs",  int'(hs2),  1);
        chk("arst_rgb", int'(rgb2), 0);
        chk("arst_x",   int'(x2),   0);
        chk("arst_y",   int'(y2),   0);
        chk("arst_vs0", int'(vs0),  1);
        @(posedge clk);
        @(negedge clk);
        chk("arst_hold_x", int'(x2), 0);
        #2 rst_n = 1'b1;
        pix_tick = 1'b1;
        toggle   = 1'b1;

        // Half-rate ticks: one advance per two clocks, full frame takes 840000 clocks.
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("tog_x%0d", i), int'(x2), tog_seq[i]);
        end
        c   = 5;
        ftn = 0;
        while (!(x2 == 10'd1 && y2 == 10'd0) && c < 850000) begin
            step();
            c++;
            if (ft2) ftn++;
        end
        chk("tog_period", c, 840000);
        chk("tog_ft_count", ftn, 1);

        summary_and_finish();
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The module SHALL have parameter PIPE_DLY, default 2: the number of pixel-tick cycles between a coordinate appearing on pix_x/pix_y and the matching colour arriving on rgb_in; legal range 0..7.
REQ-002 The module SHALL have input CLK, 1 bit: system clock, 25 MHz nominal.
REQ-003 The module SHALL have input RESET, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have input pix_tick, 1 bit: pixel enable; tie high when CLK is the pixel clock.
REQ-005 The module SHALL have input rgb_in, 12 bits: colour from the text/graphics generator, expected PIPE_DLY ticks after the coordinates that produced it.
REQ-006 The module SHALL have output pix_x, 10 bits: horizontal scan position, 0..799.
REQ-007 The module SHALL have output pix_y, 10 bits: vertical scan position, 0..524.
REQ-008 The module SHALL have output video_on, 1 bit: high when the current undelayed pix_x/pix_y lies in the visible area.
REQ-009 The module SHALL have output hsync, 1 bit: horizontal sync, active-low, aligned to vga_rgb.
REQ-010 The module SHALL have output vsync, 1 bit: vertical sync, active-low, aligned to vga_rgb.
REQ-011 The module SHALL have output vga_rgb, 12 bits: blanked colour to the DAC pins.
REQ-012 The module SHALL have output frame_tick, 1 bit: one-CLK pulse at each frame wrap.

Function
REQ-013 Horizontal timing SHALL be: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799; 800 counts per line.
REQ-014 Vertical timing SHALL be: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524; 525 lines per frame.
REQ-015 pix_x SHALL increment on each CLK edge where pix_tick=1 and wrap from 799 to 0.
REQ-016 pix_y SHALL increment only on the pix_tick cycle in which pix_x wraps, and wrap from 524 to 0 on that same cycle.
REQ-017 When pix_tick=0, pix_x, pix_y, the delay stages and every registered output SHALL hold their values.
REQ-018 video_on SHALL equal (pix_x<640) AND (pix_y<480), derived combinationally from the counters with zero latency.
REQ-019 The raw sync, raw vsync and video_on SHALL each pass through a PIPE_DLY-stage delay line that advances only on pix_tick.
REQ-020 With PIPE_DLY=0, each delay line SHALL be a wire.
REQ-021 hsync, vsync and vga_rgb SHALL be registered from the last delay stage, giving a total latency of PIPE_DLY+1 ticks from the counters.
REQ-022 vga_rgb SHALL equal rgb_in when the delayed video_on is 1, and 12'h000 otherwise.
REQ-023 No nonzero colour SHALL ever be driven while hsync=0 or vsync=0.
REQ-024 frame_tick SHALL be 1 for exactly one CLK cycle: the pix_tick cycle in which pix_x=799 and pix_y=524.
REQ-025 frame_tick SHALL be 0 on all other cycles, including whenever pix_tick=0.

Reset
REQ-026 On RESET=0, the following SHALL take effect immediately, independent of CLK: pix_x=0, pix_y=0, hsync=1, vsync=1, vga_rgb=12'h000, frame_tick=0.
REQ-027 On RESET=0, every sync delay stage SHALL reset to 1 and every video delay stage to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; scanning SHALL restart at (0,0) on the first pix_tick after RESET is released.
REQ-029 No sync pulse SHALL be emitted until the delayed raw sync goes low.

Structure
REQ-030 The timing constants SHALL live in shared package vga_timing_pkg for reuse by the text generator: H_VIS, H_FP, H_SYNC, H_BP, H_TOTAL, V_VIS, V_FP, V_SYNC, V_BP, V_TOTAL and the 12-bit colour width.
REQ-031 The three delay lines SHALL be instances of one sub-module, sync_delay_line, with parameters DEPTH and RESET_VAL, a clock enable and an asynchronous active-low reset.
REQ-032 Counters and output registers SHALL be implemented in vga_sync_gen itself; there SHALL be no other sub-modules.

Verification
REQ-033 Free-run, pix_tick=1, PIPE_DLY=2: the bench SHALL check hsync low for exactly 96 cycles per 800, starting 3 cycles after pix_x=656, and vsync low for exactly 2 lines per 525.
REQ-034 rgb_in=12'hFFF constant: the bench SHALL check vga_rgb=FFF exactly on cycles where the 3-cycle-delayed video_on=1, and 000 otherwise, including at pix_x=640..799 and pix_y=480..524.
REQ-035 pix_tick toggling 1,0,1,0: the bench SHALL check pix_x advances once per two CLKs, outputs hold on pix_tick=0 cycles, and the frame period is 2*420000 CLKs.
REQ-036 Boundary: at pix_x=799, pix_y=524 with pix_tick=1, the bench SHALL check frame_tick=1 for exactly 1 cycle and the next values are (0,0).
REQ-037 Boundary: at pix_x=799, pix_y=100, the bench SHALL check the next values are (0,101) and frame_tick stays 0.
REQ-038 RESET pulsed low at pix_x=700, pix_y=491 while vsync is low: the bench SHALL check that, asynchronously, vsync=1, hsync=1, vga_rgb=0 and the counters are 0; after release, the first tick gives pix_x=1.
REQ-039 PIPE_DLY=0 build: the bench SHALL check that sync and vga_rgb lag the counters by exactly 1 cycle.
